// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with a busy scoreboard.
// Optional write-to-read bypass and hardwired-zero x0 are parameter selected.
module regfile_sb #(
  parameter int REG_NUM     = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int READ_PORTS  = 4,
  parameter int WRITE_PORTS = 2,
  parameter int SET_PORTS   = 2,
  parameter int BYPASS      = 1,
  parameter int ZERO_KEEP   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [READ_PORTS*$clog2(REG_NUM)-1:0] raddr,
  output logic [READ_PORTS*DATA_WIDTH-1:0]      rdata,
  output logic [READ_PORTS-1:0]                 rbusy,
  input  logic [WRITE_PORTS-1:0]                wen,
  input  logic [WRITE_PORTS*$clog2(REG_NUM)-1:0] waddr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0]     wdata,
  input  logic [SET_PORTS-1:0]                  set_en,
  input  logic [SET_PORTS*$clog2(REG_NUM)-1:0]  set_addr,
  input  logic                                  flush,
  output logic [REG_NUM-1:0]                    busy_vec
);

  localparam int AW = $clog2(REG_NUM);
  localparam int DW = DATA_WIDTH;

  logic [DW-1:0]          rf [REG_NUM];
  logic [REG_NUM-1:0]     busy;
  logic [REG_NUM-1:0]     busy_nxt;

  logic [AW-1:0]          wa [WRITE_PORTS];
  logic [DW-1:0]          wd [WRITE_PORTS];
  logic [WRITE_PORTS-1:0] wok;
  logic [AW-1:0]          sa [SET_PORTS];
  logic [SET_PORTS-1:0]   sok;

  for (genvar i = 0; i < WRITE_PORTS; i++) begin : g_wr
    assign wa[i]  = waddr[i*AW +: AW];
    assign wd[i]  = wdata[i*DW +: DW];
    assign wok[i] = wen[i] &&
                    !(ZERO_KEEP != 0 && wa[i] == '0);
  end

  for (genvar j = 0; j < SET_PORTS; j++) begin : g_set
    assign sa[j]  = set_addr[j*AW +: AW];
    assign sok[j] = set_en[j] &&
                    !(ZERO_KEEP != 0 && sa[j] == '0);
  end

  // next scoreboard: writeback clears, issue sets (set wins), flush wipes
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      if (wok[i]) busy_nxt[wa[i]] = 1'b0;
    end
    for (int j = 0; j < SET_PORTS; j++) begin
      if (sok[j]) busy_nxt[sa[j]] = 1'b1;
    end
    if (flush) busy_nxt = '0;
    if (ZERO_KEEP != 0) busy_nxt[0] = 1'b0;
  end

  // all state: data array and scoreboard; later write ports win
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int r = 0; r < REG_NUM; r++) begin
        rf[r] <= '0;
      end
    end else begin
      busy <= busy_nxt;
      for (int i = 0; i < WRITE_PORTS; i++) begin
        if (wok[i]) rf[wa[i]] <= wd[i];
      end
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          rb;

    assign ra = raddr[k*AW +: AW];

    // operand select: array, then same-cycle bypass, x0 forced to zero
    always_comb begin
      rd = rf[ra];
      rb = busy[ra];
      if (BYPASS != 0) begin
        for (int i = 0; i < WRITE_PORTS; i++) begin
          if (wok[i] && wa[i] == ra) begin
            rd = wd[i];
            rb = 1'b0;
          end
        end
      end
      if (ZERO_KEEP != 0 && ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign rdata[k*DW +: DW] = rd;
    assign rbusy[k]          = rb;
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb, bypass and
// non-bypass instances sharing one set of inputs.
module tb_regfile_sb;

  localparam int RN = 32;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int RP = 4;
  localparam int WP = 2;
  localparam int SP = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [RP*AW-1:0]  raddr;
  logic [RP*DW-1:0]  rdata, rdata_n;
  logic [RP-1:0]     rbusy, rbusy_n;
  logic [WP-1:0]     wen;
  logic [WP*AW-1:0]  waddr;
  logic [WP*DW-1:0]  wdata;
  logic [SP-1:0]     set_en;
  logic [SP*AW-1:0]  set_addr;
  logic              flush;
  logic [RN-1:0]     bvec, bvec_n;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    bit          nb;
    int          kind;
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .set_en(set_en), .set_addr(set_addr),
    .flush(flush), .busy_vec(bvec)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .set_en(set_en), .set_addr(set_addr),
    .flush(flush), .busy_vec(bvec_n)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    wen      = '0;
    waddr    = '0;
    wdata    = '0;
    set_en   = '0;
    set_addr = '0;
    flush    = 1'b0;
    raddr    = '0;
  endtask

  task automatic wr(int i, int a, logic [63:0] d);
    wen[i]            = 1'b1;
    waddr[i*AW +: AW] = AW'(a);
    wdata[i*DW +: DW] = d;
  endtask

  task automatic st(int j, int a);
    set_en[j]            = 1'b1;
    set_addr[j*AW +: AW] = AW'(a);
  endtask

  task automatic rd(int k, int a);
    raddr[k*AW +: AW] = AW'(a);
  endtask

  task automatic push(string n, bit nb, int kind, int port,
                      logic [63:0] v);
    exp_t e;
    e.name = n;
    e.nb   = nb;
    e.kind = kind;
    e.port = port;
    e.exp  = v;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] probe(exp_t e);
    logic [63:0] v;
    case (e.kind)
      0: v = e.nb ? rdata_n[e.port*DW +: DW]
                  : rdata[e.port*DW +: DW];
      1: v = {63'd0, e.nb ? rbusy_n[e.port] : rbusy[e.port]};
      default: v = {32'd0, e.nb ? bvec_n : bvec};
    endcase
    return v;
  endfunction

  task automatic test_reset();
    exp_t        e;
    logic [63:0] got;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      idle();
      case (s)
        0: rst = 1'b1;
        1: begin
          rst = 1'b0;
          rd(0, 5);
          for (int n = 0; n < 2; n++) begin
            push("rst_init_rdata", n[0], 0, 0, 64'h0);
            push("rst_init_rbusy", n[0], 1, 0, 64'h0);
            push("rst_init_bvec", n[0], 2, 0, 64'h0);
          end
        end
        2: begin
          wr(0, 5, 64'h1234);
          st(0, 5);
        end
        3: begin
          rd(0, 5);
          for (int n = 0; n < 2; n++) begin
            push("pre_rdata", n[0], 0, 0, 64'h1234);
            push("pre_rbusy", n[0], 1, 0, 64'h1);
            push("pre_bvec", n[0], 2, 0, 64'h20);
          end
        end
        4: begin
          rst = 1'b1;
          wr(1, 5, 64'hFFFF);
          st(1, 6);
        end
        5: begin
          rst = 1'b0;
          rd(0, 5);
          for (int n = 0; n < 2; n++) begin
            push("rst_rdata", n[0], 0, 0, 64'h0);
            push("rst_rbusy", n[0], 1, 0, 64'h0);
            push("rst_bvec", n[0], 2, 0, 64'h0);
          end
        end
        default: ;
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        got = probe(e);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s nb=%0d: got %h required %h",
                   e.name, e.nb, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_basic();
    exp_t        e;
    logic [63:0] got;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      idle();
      rd(0, 3);
      case (s)
        0: begin
          wr(0, 3, 64'hDEAD_BEEF);
          push("basic_same_nb", 1'b1, 0, 0, 64'h0);
          push("basic_same_byp", 1'b0, 0, 0, 64'hDEAD_BEEF);
          push("basic_same_byp_busy", 1'b0, 1, 0, 64'h0);
        end
        1: begin
          push("basic_next_nb", 1'b1, 0, 0, 64'hDEAD_BEEF);
          push("basic_next_byp", 1'b0, 0, 0, 64'hDEAD_BEEF);
        end
        default: ;
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        got = probe(e);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s nb=%0d: got %h required %h",
                   e.name, e.nb, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_bypass_prio();
    exp_t        e;
    logic [63:0] got;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      idle();
      rd(1, 7);
      case (s)
        0: begin
          wr(0, 7, 64'hAA);
          wr(1, 7, 64'hBB);
          push("prio_byp", 1'b0, 0, 1, 64'hBB);
          push("prio_byp_busy", 1'b0, 1, 1, 64'h0);
          push("prio_nb", 1'b1, 0, 1, 64'h0);
        end
        1: begin
          push("prio_next_byp", 1'b0, 0, 1, 64'hBB);
          push("prio_next_nb", 1'b1, 0, 1, 64'hBB);
        end
        default: ;
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        got = probe(e);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s nb=%0d: got %h required %h",
                   e.name, e.nb, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t        e;
    logic [63:0] got;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      idle();
      rd(2, 9);
      case (s)
        0: begin
          st(0, 9);
          push("sb_set_same_byp", 1'b0, 1, 2, 64'h0);
          push("sb_set_same_nb", 1'b1, 1, 2, 64'h0);
        end
        1: begin
          push("sb_busy_byp", 1'b0, 1, 2, 64'h1);
          push("sb_busy_nb", 1'b1, 1, 2, 64'h1);
          push("sb_bvec", 1'b0, 2, 0, 64'h200);
        end
        3: begin
          wr(1, 9, 64'h55);
          push("sb_wb_byp", 1'b0, 0, 2, 64'h55);
          push("sb_wb_byp_busy", 1'b0, 1, 2, 64'h0);
          push("sb_wb_nb", 1'b1, 0, 2, 64'h0);
          push("sb_wb_nb_busy", 1'b1, 1, 2, 64'h1);
        end
        4: begin
          push("sb_after_byp", 1'b0, 0, 2, 64'h55);
          push("sb_after_nb_busy", 1'b1, 1, 2, 64'h0);
          push("sb_after_bvec", 1'b0, 2, 0, 64'h0);
          push("sb_after_bvec_nb", 1'b1, 2, 0, 64'h0);
        end
        default: ;
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        got = probe(e);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s nb=%0d: got %h required %h",
                   e.name, e.nb, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_collision();
    exp_t        e;
    logic [63:0] got;
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      idle();
      rd(3, 4);
      case (s)
        0: begin
          st(1, 4);
          wr(0, 4, 64'h11);
        end
        1: begin
          for (int n = 0; n < 2; n++) begin
            push("col_rdata", n[0], 0, 3, 64'h11);
            push("col_rbusy", n[0], 1, 3, 64'h1);
            push("col_bvec", n[0], 2, 0, 64'h10);
          end
        end
        2: begin
          flush = 1'b1;
          st(0, 4);
          push("flush_same_busy", 1'b0, 1, 3, 64'h1);
        end
        3: begin
          for (int n = 0; n < 2; n++) begin
            push("flush_rbusy", n[0], 1, 3, 64'h0);
            push("flush_bvec", n[0], 2, 0, 64'h0);
          end
        end
        default: ;
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        got = probe(e);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s nb=%0d: got %h required %h",
                   e.name, e.nb, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_zero();
    exp_t        e;
    logic [63:0] got;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      idle();
      rd(0, 0);
      if (s == 0) begin
        wr(0, 0, 64'hFF);
        wr(1, 0, 64'hFF);
        st(0, 0);
        st(1, 0);
      end
      for (int n = 0; n < 2; n++) begin
        push("x0_rdata", n[0], 0, 0, 64'h0);
        push("x0_rbusy", n[0], 1, 0, 64'h0);
        push("x0_bvec", n[0], 2, 0, 64'h0);
      end
      @(negedge clk);
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        got = probe(e);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s nb=%0d: got %h required %h",
                   e.name, e.nb, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [63:0] got;
    logic [63:0] mrf [RN];
    logic [RN-1:0] mb;
    logic [AW-1:0] a, wa0, wa1, sa0, sa1;
    logic [63:0] wd0, wd1, nd, bd;
    logic        nbz, bb;

    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int r = 0; r < RN; r++) mrf[r] = '0;
    mb = '0;

    for (int c = 0; c < 300; c++) begin
      idle();
      for (int i = 0; i < WP; i++) begin
        if ($urandom_range(0, 2) != 0)
          wr(i, $urandom_range(0, 7),
             {$urandom, $urandom});
      end
      for (int j = 0; j < SP; j++) begin
        if ($urandom_range(0, 2) == 0)
          st(j, $urandom_range(0, 7));
      end
      flush = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < RP; k++)
        rd(k, (c % 5 == 0) ? $urandom_range(0, 31)
                           : $urandom_range(0, 7));

      wa0 = waddr[0 +: AW];
      wa1 = waddr[AW +: AW];
      wd0 = wdata[0 +: DW];
      wd1 = wdata[DW +: DW];
      sa0 = set_addr[0 +: AW];
      sa1 = set_addr[AW +: AW];

      for (int k = 0; k < RP; k++) begin
        a   = raddr[k*AW +: AW];
        nd  = mrf[a];
        nbz = mb[a];
        bd  = nd;
        bb  = nbz;
        if (wen[0] && wa0 == a) begin bd = wd0; bb = 1'b0; end
        if (wen[1] && wa1 == a) begin bd = wd1; bb = 1'b0; end
        if (a == '0) begin
          nd = '0; nbz = 1'b0; bd = '0; bb = 1'b0;
        end
        push("b2b_rdata", 1'b0, 0, k, bd);
        push("b2b_rbusy", 1'b0, 1, k, {63'd0, bb});
        push("b2b_rdata", 1'b1, 0, k, nd);
        push("b2b_rbusy", 1'b1, 1, k, {63'd0, nbz});
      end
      push("b2b_bvec", 1'b0, 2, 0, {32'd0, mb});
      push("b2b_bvec", 1'b1, 2, 0, {32'd0, mb});

      if (wen[0] && wa0 != '0) mrf[wa0] = wd0;
      if (wen[1] && wa1 != '0) mrf[wa1] = wd1;
      if (flush) begin
        mb = '0;
      end else begin
        if (wen[0]) mb[wa0] = 1'b0;
        if (wen[1]) mb[wa1] = 1'b0;
        if (set_en[0]) mb[sa0] = 1'b1;
        if (set_en[1]) mb[sa1] = 1'b1;
        mb[0] = 1'b0;
      end

      @(negedge clk);
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        got = probe(e);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s nb=%0d port=%0d cyc=%0d: got %h required %h",
                   e.name, e.nb, e.port, c, got, e.exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_bypass_prio();
    test_scoreboard();
    test_collision();
    test_zero();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
